and2_pulse_scheduler: RTL and testbench

AND2_PULSE_SCHEDULER -- requirements
Module: and2_pulse_scheduler

---
 rtl/and2sched_pkg.sv | 15 +
 rtl/and2sched_rr_arb.sv | 32 +++
 rtl/and2_pulse_scheduler.sv | 128 ++++++++++++
 tb/tb_and2_pulse_scheduler.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/and2sched_pkg.sv
// Shared types and constants for the AND2 pulse scheduler.
package and2sched_pkg;

   localparam int CNT_W = 4;
   localparam int N_REQ = 2;

   typedef enum logic [2:0] {
      IDLE,
      GUARD,
      CLOCK,
      WAIT,
      RESP
   } state_e;

endpackage

// File: rtl/and2sched_rr_arb.sv
// Two-way round-robin arbiter: pointer side wins a tie, a lone requester always wins.
module and2sched_rr_arb
   import and2sched_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N_REQ-1:0] valid,
   input  logic             en,
   output logic [N_REQ-1:0] grant,
   output logic             gnt_id
);

   logic ptr;

   always_comb begin
      gnt_id = valid[1];
      if (valid[0] && valid[1])
         gnt_id = ptr;
      grant = '0;
      if (|valid)
         grant[gnt_id] = 1'b1;
   end

   // Pointer moves away from whoever was just served.
   always_ff @(posedge clk) begin
      if (!rst_n)
         ptr <= 1'b0;
      else if (en)
         ptr <= ~gnt_id;
   end

endmodule

// File: rtl/and2_pulse_scheduler.sv
// Serialises two requesters onto a toggle-encoded AND2 cell: operands, guard, clock, wait, respond.
// Optional spurious-output checker enabled by defining AND2SCHED_ERRCHK_EN.
module and2_pulse_scheduler
   import and2sched_pkg::*;
#(
   parameter int GUARD_CYC = 2,
   parameter int RESP_CYC  = 3
) (
   input  logic clk,
   input  logic rst_n,
   input  logic req0_valid,
   input  logic req0_a,
   input  logic req0_b,
   output logic req0_ready,
   input  logic req1_valid,
   input  logic req1_a,
   input  logic req1_b,
   output logic req1_ready,
   output logic rsp_valid,
   output logic rsp_id,
   output logic rsp_q,
   input  logic rsp_ready,
   output logic cell_a,
   output logic cell_b,
   output logic cell_clk,
   input  logic cell_q,
   output logic err
);

   state_e           state;
   logic [CNT_W-1:0] cnt;
   logic             q_ref;
   logic             id_q;
   logic [N_REQ-1:0] req_valid;
   logic [N_REQ-1:0] grant;
   logic             gnt_id;
   logic             idle;
   logic             accept;
   logic             sel_a;
   logic             sel_b;

   assign req_valid  = {req1_valid, req0_valid};
   assign idle       = rst_n && (state == IDLE);
   assign accept     = idle && (|req_valid);
   assign req0_ready = idle && grant[0];
   assign req1_ready = idle && grant[1];
   assign sel_a      = gnt_id ? req1_a : req0_a;
   assign sel_b      = gnt_id ? req1_b : req0_b;

   and2sched_rr_arb u_arb (
      .clk    (clk),
      .rst_n  (rst_n),
      .valid  (req_valid),
      .en     (accept),
      .grant  (grant),
      .gnt_id (gnt_id)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         cnt       <= '0;
         cell_a    <= 1'b0;
         cell_b    <= 1'b0;
         cell_clk  <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_id    <= 1'b0;
         rsp_q     <= 1'b0;
         q_ref     <= 1'b0;
         id_q      <= 1'b0;
      end else begin
         case (state)
            IDLE: if (accept) begin
               // Operand pulses go out on the accept edge; a zero operand sends none.
               id_q   <= gnt_id;
               cell_a <= cell_a ^ sel_a;
               cell_b <= cell_b ^ sel_b;
               cnt    <= CNT_W'(GUARD_CYC - 1);
               state  <= GUARD;
            end
            GUARD: begin
               if (cnt == '0) begin
                  cell_clk <= ~cell_clk;
                  state    <= CLOCK;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            CLOCK: begin
               q_ref <= cell_q;
               cnt   <= CNT_W'(RESP_CYC - 1);
               state <= WAIT;
            end
            WAIT: begin
               if (cnt == '0) begin
                  rsp_valid <= 1'b1;
                  rsp_id    <= id_q;
                  rsp_q     <= cell_q ^ q_ref;
                  state     <= RESP;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            RESP: if (rsp_ready) begin
               rsp_valid <= 1'b0;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef AND2SCHED_ERRCHK_EN
   logic q_d;

   // Any cell output edge outside the clock/wait window is spurious.
   always_ff @(posedge clk) begin
      q_d <= cell_q;
      if (!rst_n)
         err <= 1'b0;
      else if ((cell_q != q_d) && (state == IDLE || state == GUARD || state == RESP))
         err <= 1'b1;
   end
`else
   assign err = 1'b0;
`endif

endmodule

// File: tb/tb_and2_pulse_scheduler.sv
// Directed vector bench for and2_pulse_scheduler (GUARD_CYC=2, RESP_CYC=2).
module tb_and2_pulse_scheduler;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic req0_valid = 1'b0, req0_a = 1'b0, req0_b = 1'b0, req0_ready;
   logic req1_valid = 1'b0, req1_a = 1'b0, req1_b = 1'b0, req1_ready;
   logic rsp_valid, rsp_id, rsp_q;
   logic rsp_ready = 1'b0;
   logic cell_a, cell_b, cell_clk;
   logic cell_q = 1'b0;
   logic err;

   int total = 0;
   int passed = 0;

   always #5 clk = ~clk;

   and2_pulse_scheduler #(.GUARD_CYC(2), .RESP_CYC(2)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req0_valid (req0_valid),
      .req0_a     (req0_a),
      .req0_b     (req0_b),
      .req0_ready (req0_ready),
      .req1_valid (req1_valid),
      .req1_a     (req1_a),
      .req1_b     (req1_b),
      .req1_ready (req1_ready),
      .rsp_valid  (rsp_valid),
      .rsp_id     (rsp_id),
      .rsp_q      (rsp_q),
      .rsp_ready  (rsp_ready),
      .cell_a     (cell_a),
      .cell_b     (cell_b),
      .cell_clk   (cell_clk),
      .cell_q     (cell_q),
      .err        (err)
   );

   typedef struct {
      logic r0v, r0a, r0b;
      logic r1v, r1a, r1b;
      logic qt;      // toggle cell_q during WAIT
      logic gnt;     // expected winner / rsp_id
      logic ta, tb;  // expected cell_a / cell_b toggles
      logic q;       // expected rsp_q
      int   stall;   // cycles rsp_ready held low
   } vec_t;

   vec_t tbl[7];

   task automatic chk(input string name, input logic act, input logic exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %b want %b", name, act, exp);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      rsp_ready = 1'b0;
      @(negedge clk);
      chk("rst_ready0", req0_ready, 1'b0);
      chk("rst_ready1", req1_ready, 1'b0);
      @(negedge clk);
      chk("rst_cell_a", cell_a, 1'b0);
      chk("rst_cell_b", cell_b, 1'b0);
      chk("rst_cell_clk", cell_clk, 1'b0);
      chk("rst_rsp_valid", rsp_valid, 1'b0);
      chk("rst_rsp_id", rsp_id, 1'b0);
      chk("rst_rsp_q", rsp_q, 1'b0);
      chk("rst_err", err, 1'b0);
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      rst_n = 1'b1;
   endtask

   // Called at a negedge with the DUT in IDLE; returns at a negedge with the DUT back in IDLE.
   task automatic run_txn(input vec_t v);
      logic a0, b0, c0;
      req0_valid = v.r0v; req0_a = v.r0a; req0_b = v.r0b;
      req1_valid = v.r1v; req1_a = v.r1a; req1_b = v.r1b;
      rsp_ready = 1'b0;
      #1;
      chk("grant_ready0", req0_ready, v.gnt == 1'b0);
      chk("grant_ready1", req1_ready, v.gnt == 1'b1);
      a0 = cell_a; b0 = cell_b; c0 = cell_clk;
      @(negedge clk);  // T+1
      if (v.gnt) req1_valid = 1'b0; else req0_valid = 1'b0;
      chk("t1_cell_a", cell_a, a0 ^ v.ta);
      chk("t1_cell_b", cell_b, b0 ^ v.tb);
      chk("t1_cell_clk", cell_clk, c0);
      chk("busy_ready", req0_ready | req1_ready, 1'b0);
      @(negedge clk);  // T+2
      chk("t2_cell_clk", cell_clk, c0);
      @(negedge clk);  // T+3
      chk("t3_cell_clk", cell_clk, ~c0);
      chk("t3_cell_a", cell_a, a0 ^ v.ta);
      chk("t3_cell_b", cell_b, b0 ^ v.tb);
      @(negedge clk);  // T+4
      if (v.qt) cell_q = ~cell_q;
      @(negedge clk);  // T+5
      chk("t5_rsp_valid", rsp_valid, 1'b0);
      chk("t5_cell_a", cell_a, a0 ^ v.ta);
      chk("t5_cell_b", cell_b, b0 ^ v.tb);
      chk("t5_cell_clk", cell_clk, ~c0);
      @(negedge clk);  // T+6
      chk("t6_rsp_valid", rsp_valid, 1'b1);
      chk("t6_rsp_id", rsp_id, v.gnt);
      chk("t6_rsp_q", rsp_q, v.q);
      for (int k = 0; k < v.stall; k++) begin
         @(negedge clk);
         chk("stall_rsp_valid", rsp_valid, 1'b1);
         chk("stall_rsp_id", rsp_id, v.gnt);
         chk("stall_rsp_q", rsp_q, v.q);
         chk("stall_ready", req0_ready | req1_ready, 1'b0);
         chk("stall_cell_clk", cell_clk, ~c0);
      end
      rsp_ready = 1'b1;
      #1;
      chk("resp_no_accept", req0_ready | req1_ready, 1'b0);
      @(negedge clk);
      rsp_ready = 1'b0;
      chk("post_rsp_valid", rsp_valid, 1'b0);
      chk("post_idle_ready", req0_ready | req1_ready, req0_valid | req1_valid);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t late;
      //          r0v   r0a   r0b   r1v   r1a   r1b   qt    gnt   ta    tb    q    stall
      tbl[0] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 0};
      tbl[1] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0};
      tbl[2] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0};
      tbl[3] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 0};
      tbl[4] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 0};
      tbl[5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 5};
      tbl[6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 0};
      late   = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 0};

      do_reset();
      for (int i = 0; i < 7; i++) begin
         if (i == 2) do_reset();
         run_txn(tbl[i]);
      end

      // Reset while in GUARD drops the transaction entirely.
      do_reset();
      req0_valid = 1'b1; req0_a = 1'b1; req0_b = 1'b1;
      #1;
      chk("abort_ready0", req0_ready, 1'b1);
      @(negedge clk);
      req0_valid = 1'b0;
      chk("abort_cell_a", cell_a, 1'b1);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      chk("abort_rst_cell_a", cell_a, 1'b0);
      chk("abort_rst_cell_b", cell_b, 1'b0);
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         chk("abort_cell_clk", cell_clk, 1'b0);
         chk("abort_rsp_valid", rsp_valid, 1'b0);
      end
      run_txn(late);

      // Cell output edge while idle.
      cell_q = ~cell_q;
      @(negedge clk);
      @(negedge clk);
`ifdef AND2SCHED_ERRCHK_EN
      chk("err_set", err, 1'b1);
      @(negedge clk);
      chk("err_sticky", err, 1'b1);
`else
      chk("err_tied", err, 1'b0);
      @(negedge clk);
      chk("err_tied2", err, 1'b0);
`endif

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
